video_slot_sequencer: RTL and testbench

Parametrised timing sequencer for the video/CGA datapath. A free-running period counter divides each character period into equal lanes. Within each lane it decodes the fixed slot pulses for VRAM fetch, character-ROM read, display pipeline and CRTC clock. It also arbitrates ISA host accesses into the guarded idle window of each lane. The lane mode is latched at period boundaries, so a mode change never produces a truncated or doubled fetch. The block replaces the fixed 32-cycle, 2-lane sequencer used by the CGA path.

---
 rtl/video_slot_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_video_slot_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_slot_sequencer.sv
// -----------------------------------------------------------------------------
// video_slot_sequencer
//
// Timing sequencer for the video/CGA datapath. A free-running period counter
// of 2^PERIOD_LOG2 cycles is split into 2^LANES_LOG2 equal lanes. In each lane
// it decodes the fixed slot pulses for VRAM fetch, character-ROM read, the
// display pipeline and the CRTC clock. It also grants ISA host accesses inside
// the guarded idle window of each lane. The lane mode is latched only at the
// period boundary, so a mode change never truncates or doubles a fetch.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   lane_sel       in   requested active lanes = 2^min(lane_sel, LANES_LOG2)
//   isa_req        in   level request for an ISA VRAM operation
//   clk_seq        out  current period counter value
//   lane_idx       out  current physical lane
//   lclk           out  pulse at clk_seq == 0
//   hclk           out  pulse at offset 0 of every physical lane
//   crtc_clk       out  pulse at offset 0 of active lanes
//   vram_read      out  offsets 1..3 of every physical lane
//   vram_read_a0   out  offset 2 of every physical lane
//   vram_read_char out  offset 2 of active lanes
//   vram_read_att  out  offset 3 of active lanes
//   charrom_read   out  offset 3 of active lanes
//   disp_pipeline  out  offset 4 of active lanes
//   isa_op_enable  out  offsets 5..L-2 of every lane
//   isa_start      out  same-cycle grant pulse for a legal ISA request
//   isa_busy       out  high for ISA_OP_CYCLES cycles starting at isa_start
// -----------------------------------------------------------------------------
module video_slot_sequencer #(
  parameter int PERIOD_LOG2   = 5,
  parameter int LANES_LOG2    = 1,
  parameter int ISA_OP_CYCLES = 3,
  parameter int ISA_GUARD     = 2,
  localparam int LANE_W       = (LANES_LOG2 > 0) ? LANES_LOG2 : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             lane_sel,
  input  logic                   isa_req,
  output logic [PERIOD_LOG2-1:0] clk_seq,
  output logic [LANE_W-1:0]      lane_idx,
  output logic                   lclk,
  output logic                   hclk,
  output logic                   crtc_clk,
  output logic                   vram_read,
  output logic                   vram_read_a0,
  output logic                   vram_read_char,
  output logic                   vram_read_att,
  output logic                   charrom_read,
  output logic                   disp_pipeline,
  output logic                   isa_op_enable,
  output logic                   isa_start,
  output logic                   isa_busy
);

  localparam int OFF_W      = PERIOD_LOG2 - LANES_LOG2;
  localparam int LANE_LEN   = 1 << OFF_W;
  localparam int MODE_W     = (LANES_LOG2 > 0) ? $clog2(LANES_LOG2 + 1) : 1;
  localparam int CNT_W      = (ISA_OP_CYCLES > 2) ? $clog2(ISA_OP_CYCLES) : 1;
  // Latest offset at which an op plus its guard still ends before the next
  // lane's first vram_read (offset 1 of the following lane).
  localparam int LAST_START = LANE_LEN + 1 - ISA_OP_CYCLES - ISA_GUARD;
  localparam int FIRST_START = 5;

  localparam logic [PERIOD_LOG2-1:0] SEQ_LAST = '1;

  typedef struct packed {
    logic lclk;
    logic hclk;
    logic crtc_clk;
    logic vram_read;
    logic vram_read_a0;
    logic vram_read_char;
    logic vram_read_att;
    logic charrom_read;
    logic disp_pipeline;
    logic isa_op_enable;
  } slots_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Clamp the requested lane count to what the period physically provides.
  function automatic logic [MODE_W-1:0] eff_mode(input logic [1:0] sel);
    int s;
    s = int'(sel);
    if (s > LANES_LOG2) begin
      return MODE_W'(LANES_LOG2);
    end else begin
      return MODE_W'(s);
    end
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(input logic [PERIOD_LOG2-1:0] seq);
    return LANE_W'(seq >> OFF_W);
  endfunction

  // A lane is active when its index is a multiple of the stride
  // 2^(LANES_LOG2 - mode), i.e. its low stride bits are all zero.
  function automatic logic lane_active(input logic [LANE_W-1:0] lane,
                                       input logic [MODE_W-1:0] mode);
    int stride_log2;
    logic [LANE_W-1:0] mask;
    stride_log2 = LANES_LOG2 - int'(mode);
    mask = '0;
    for (int b = 0; b < LANE_W; b++) begin
      mask[b] = (b < stride_log2) ? 1'b1 : 1'b0;
    end
    return ((lane & mask) == '0);
  endfunction

  function automatic slots_t decode(input logic [PERIOD_LOG2-1:0] seq,
                                    input logic [MODE_W-1:0]      mode);
    slots_t s;
    logic [OFF_W-1:0] off;
    logic act;
    off = seq[OFF_W-1:0];
    act = lane_active(lane_of(seq), mode);
    s.lclk           = (seq == '0);
    s.hclk           = (off == OFF_W'(0));
    s.crtc_clk       = act && (off == OFF_W'(0));
    s.vram_read      = (off >= OFF_W'(1)) && (off <= OFF_W'(3));
    s.vram_read_a0   = (off == OFF_W'(2));
    s.vram_read_char = act && (off == OFF_W'(2));
    s.vram_read_att  = act && (off == OFF_W'(3));
    s.charrom_read   = act && (off == OFF_W'(3));
    s.disp_pipeline  = act && (off == OFF_W'(4));
    s.isa_op_enable  = (off >= OFF_W'(5)) && (off <= OFF_W'(LANE_LEN - 2));
    return s;
  endfunction

  logic [PERIOD_LOG2-1:0] clk_seq_q, clk_seq_d;
  logic [MODE_W-1:0]      mode_q, mode_d;
  logic [LANE_W-1:0]      lane_idx_q, lane_idx_d;
  slots_t                 slots_q, slots_d;
  arb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       op_cnt_q, op_cnt_d;
  logic [OFF_W-1:0]       off_now;
  logic                   isa_legal;

  // Next counter/mode values; slot outputs are decoded from the next state and
  // registered, so each output equals the decode of the current counter and
  // mode while coming straight from a flop (no decode glitches).
  always_comb begin
    clk_seq_d = clk_seq_q + PERIOD_LOG2'(1);
    if (clk_seq_q == SEQ_LAST) begin
      mode_d = eff_mode(lane_sel);
    end else begin
      mode_d = mode_q;
    end
    lane_idx_d = lane_of(clk_seq_d);
    slots_d    = decode(clk_seq_d, mode_d);
  end

  // Period counter, mode latch and registered slot decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_seq_q  <= SEQ_LAST;
      mode_q     <= '0;
      lane_idx_q <= lane_of(SEQ_LAST);
      slots_q    <= '0;
    end else begin
      clk_seq_q  <= clk_seq_d;
      mode_q     <= mode_d;
      lane_idx_q <= lane_idx_d;
      slots_q    <= slots_d;
    end
  end

  // Grant window: offset must be past the display slots and leave room for the
  // op plus guard before the next lane's fetch.
  always_comb begin
    off_now   = clk_seq_q[OFF_W-1:0];
    isa_legal = (int'(off_now) >= FIRST_START) && (int'(off_now) <= LAST_START);
    isa_start = (state_q == ARB_IDLE) && isa_req && isa_legal;
    isa_busy  = isa_start || (state_q == ARB_BUSY);
  end

  // Arbiter next state: BUSY covers the op cycles after the grant cycle.
  always_comb begin
    state_d  = state_q;
    op_cnt_d = op_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (isa_start && (ISA_OP_CYCLES > 1)) begin
          state_d  = ARB_BUSY;
          op_cnt_d = CNT_W'(ISA_OP_CYCLES - 1);
        end else begin
          state_d  = ARB_IDLE;
          op_cnt_d = '0;
        end
      end
      ARB_BUSY: begin
        if (op_cnt_q == CNT_W'(1)) begin
          state_d  = ARB_IDLE;
          op_cnt_d = '0;
        end else begin
          state_d  = ARB_BUSY;
          op_cnt_d = op_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        op_cnt_d = '0;
      end
    endcase
  end

  // ISA arbiter state; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign clk_seq        = clk_seq_q;
  assign lane_idx       = lane_idx_q;
  assign lclk           = slots_q.lclk;
  assign hclk           = slots_q.hclk;
  assign crtc_clk       = slots_q.crtc_clk;
  assign vram_read      = slots_q.vram_read;
  assign vram_read_a0   = slots_q.vram_read_a0;
  assign vram_read_char = slots_q.vram_read_char;
  assign vram_read_att  = slots_q.vram_read_att;
  assign charrom_read   = slots_q.charrom_read;
  assign disp_pipeline  = slots_q.disp_pipeline;
  assign isa_op_enable  = slots_q.isa_op_enable;

endmodule

// File: tb/tb_video_slot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_video_slot_sequencer
//
// Directed self-checking bench. One instance uses the default 32-cycle,
// 2-lane configuration; a second uses PERIOD_LOG2=6, LANES_LOG2=2 with
// lane_sel fixed at 1. The bench tracks its own expected counter values.
// -----------------------------------------------------------------------------
module tb_video_slot_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] lane_sel = 2'd1;
  logic [1:0] lane_sel_w = 2'd1;
  logic       isa_req = 1'b0;

  logic [4:0] clk_seq;
  logic [0:0] lane_idx;
  logic lclk, hclk, crtc_clk, vram_read, vram_read_a0, vram_read_char;
  logic vram_read_att, charrom_read, disp_pipeline, isa_op_enable;
  logic isa_start, isa_busy;

  logic [5:0] clk_seq_w;
  logic [1:0] lane_idx_w;
  logic lclk_w, hclk_w, crtc_clk_w, vram_read_w, vram_read_a0_w, vram_read_char_w;
  logic vram_read_att_w, charrom_read_w, disp_pipeline_w, isa_op_enable_w;
  logic isa_start_w, isa_busy_w;
  logic isa_req_w = 1'b0;

  logic [9:0] slots_v;
  logic [9:0] slots_w;

  int checks = 0;
  int errors = 0;
  int exp_seq = 31;
  int exp_w = 63;

  always #5 clk = ~clk;

  assign slots_v = {lclk, hclk, crtc_clk, vram_read, vram_read_a0, vram_read_char,
                    vram_read_att, charrom_read, disp_pipeline, isa_op_enable};
  assign slots_w = {lclk_w, hclk_w, crtc_clk_w, vram_read_w, vram_read_a0_w, vram_read_char_w,
                    vram_read_att_w, charrom_read_w, disp_pipeline_w, isa_op_enable_w};

  video_slot_sequencer dut (
    .clk(clk), .reset_n(reset_n), .lane_sel(lane_sel), .isa_req(isa_req),
    .clk_seq(clk_seq), .lane_idx(lane_idx), .lclk(lclk), .hclk(hclk),
    .crtc_clk(crtc_clk), .vram_read(vram_read), .vram_read_a0(vram_read_a0),
    .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
    .charrom_read(charrom_read), .disp_pipeline(disp_pipeline),
    .isa_op_enable(isa_op_enable), .isa_start(isa_start), .isa_busy(isa_busy)
  );

  video_slot_sequencer #(.PERIOD_LOG2(6), .LANES_LOG2(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .lane_sel(lane_sel_w), .isa_req(isa_req_w),
    .clk_seq(clk_seq_w), .lane_idx(lane_idx_w), .lclk(lclk_w), .hclk(hclk_w),
    .crtc_clk(crtc_clk_w), .vram_read(vram_read_w), .vram_read_a0(vram_read_a0_w),
    .vram_read_char(vram_read_char_w), .vram_read_att(vram_read_att_w),
    .charrom_read(charrom_read_w), .disp_pipeline(disp_pipeline_w),
    .isa_op_enable(isa_op_enable_w), .isa_start(isa_start_w), .isa_busy(isa_busy_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
    exp_seq = (exp_seq + 1) % 32;
    exp_w   = (exp_w + 1) % 64;
  endtask

  task automatic do_reset(input logic [1:0] sel);
    reset_n  = 1'b0;
    lane_sel = sel;
    isa_req  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_seq = 31;
    exp_w   = 63;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    lane_sel = 2'd1;
    isa_req  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (clk_seq !== 5'd31) begin
      errors++;
      $display("FAIL reset_clk_seq got %0d expected 31", clk_seq);
    end
    checks++;
    if (clk_seq_w !== 6'd63) begin
      errors++;
      $display("FAIL reset_clk_seq_wide got %0d expected 63", clk_seq_w);
    end
    checks++;
    if (slots_v !== 10'b0 || slots_w !== 10'b0) begin
      errors++;
      $display("FAIL reset_slots got %b/%b expected 0/0", slots_v, slots_w);
    end
    checks++;
    if (isa_start !== 1'b0 || isa_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_isa got start=%b busy=%b expected 0 0", isa_start, isa_busy);
    end
    checks++;
    if (lane_idx !== 1'd1) begin
      errors++;
      $display("FAIL reset_lane_idx got %0d expected 1", lane_idx);
    end
    reset_n = 1'b1;
    exp_seq = 31;
    exp_w   = 63;
    step();
    checks++;
    if (clk_seq !== 5'd0 || lclk !== 1'b1 || hclk !== 1'b1 || crtc_clk !== 1'b1) begin
      errors++;
      $display("FAIL first_edge got seq=%0d lclk=%b hclk=%b crtc=%b expected 0 1 1 1",
               clk_seq, lclk, hclk, crtc_clk);
    end
  endtask

  task automatic test_two_lanes();
    logic [9:0] exp_v;
    int off;
    do_reset(2'd1);
    for (int i = 0; i < 64; i++) begin
      step();
      off = exp_seq % 16;
      exp_v = {exp_seq == 0, off == 0, off == 0, (off >= 1 && off <= 3), off == 2,
               off == 2, off == 3, off == 3, off == 4, (off >= 5 && off <= 14)};
      checks++;
      if (clk_seq !== 5'(exp_seq) || lane_idx !== 1'(exp_seq / 16)) begin
        errors++;
        $display("FAIL two_lanes_seq got %0d/%0d expected %0d/%0d",
                 clk_seq, lane_idx, exp_seq, exp_seq / 16);
      end
      checks++;
      if (slots_v !== exp_v) begin
        errors++;
        $display("FAIL two_lanes_slots seq=%0d got %b expected %b", exp_seq, slots_v, exp_v);
      end
    end
  endtask

  task automatic test_one_lane();
    logic [9:0] exp_v;
    int off;
    logic act;
    do_reset(2'd0);
    for (int i = 0; i < 32; i++) begin
      step();
      off = exp_seq % 16;
      act = (exp_seq < 16);
      exp_v = {exp_seq == 0, off == 0, act && off == 0, (off >= 1 && off <= 3), off == 2,
               act && off == 2, act && off == 3, act && off == 3, act && off == 4,
               (off >= 5 && off <= 14)};
      checks++;
      if (slots_v !== exp_v) begin
        errors++;
        $display("FAIL one_lane_slots seq=%0d got %b expected %b", exp_seq, slots_v, exp_v);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [9:0] exp_v;
    int off;
    logic act;
    do_reset(2'd0);
    for (int i = 0; i < 64; i++) begin
      step();
      if (i == 10) begin
        lane_sel = 2'd1;
      end
      off = exp_seq % 16;
      act = (exp_seq < 16) || (i >= 32);
      exp_v = {exp_seq == 0, off == 0, act && off == 0, (off >= 1 && off <= 3), off == 2,
               act && off == 2, act && off == 3, act && off == 3, act && off == 4,
               (off >= 5 && off <= 14)};
      checks++;
      if (slots_v !== exp_v) begin
        errors++;
        $display("FAIL mode_switch_slots cycle=%0d got %b expected %b", i, slots_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_start;
    logic exp_busy;
    do_reset(2'd1);
    for (int i = 0; i < 48; i++) begin
      step();
      if (i == 13) begin
        isa_req = 1'b1;
        #1;
      end
      exp_start = (i == 21) || (i == 24) || (i == 27) || (i == 37) || (i == 40) || (i == 43);
      exp_busy  = (i >= 21 && i <= 29) || (i >= 37 && i <= 45);
      checks++;
      if (isa_start !== exp_start || isa_busy !== exp_busy) begin
        errors++;
        $display("FAIL isa_grant cycle=%0d got start=%b busy=%b expected %b %b",
                 i, isa_start, isa_busy, exp_start, exp_busy);
      end
    end
    isa_req = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    do_reset(2'd1);
    for (int i = 0; i <= 22; i++) begin
      step();
      if (i == 20) begin
        isa_req = 1'b1;
      end
    end
    checks++;
    if (clk_seq !== 5'd22 || isa_busy !== 1'b1 || isa_start !== 1'b0) begin
      errors++;
      $display("FAIL busy_before_reset got seq=%0d busy=%b start=%b expected 22 1 0",
               clk_seq, isa_busy, isa_start);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (clk_seq !== 5'd31 || isa_busy !== 1'b0 || isa_start !== 1'b0 || slots_v !== 10'b0) begin
      errors++;
      $display("FAIL reset_abort got seq=%0d busy=%b start=%b slots=%b expected 31 0 0 0",
               clk_seq, isa_busy, isa_start, slots_v);
    end
    isa_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_seq = 31;
    exp_w   = 63;
    step();
    checks++;
    if (clk_seq !== 5'd0 || lclk !== 1'b1) begin
      errors++;
      $display("FAIL release_lclk got seq=%0d lclk=%b expected 0 1", clk_seq, lclk);
    end
  endtask

  task automatic test_wide();
    int off;
    int lane;
    logic act;
    do_reset(2'd1);
    for (int i = 0; i < 64; i++) begin
      step();
      off  = exp_w % 16;
      lane = exp_w / 16;
      act  = (lane == 0) || (lane == 2);
      checks++;
      if (clk_seq_w !== 6'(exp_w) || lane_idx_w !== 2'(lane)) begin
        errors++;
        $display("FAIL wide_seq got %0d/%0d expected %0d/%0d", clk_seq_w, lane_idx_w, exp_w, lane);
      end
      checks++;
      if (hclk_w !== (off == 0) || crtc_clk_w !== (act && off == 0) ||
          vram_read_char_w !== (act && off == 2)) begin
        errors++;
        $display("FAIL wide_slots seq=%0d got hclk=%b crtc=%b char=%b expected %b %b %b",
                 exp_w, hclk_w, crtc_clk_w, vram_read_char_w,
                 off == 0, act && off == 0, act && off == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_lanes();
    test_one_lane();
    test_mode_switch();
    test_back_to_back();
    test_reset_mid_busy();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
